mips_core: RTL and testbench

- Single-cycle 32-bit MIPS processor: PC, byte-addressed instruction memory, 32x32 register file, ALU, byte-addressed data memory.
- Each rising clock edge executes exactly one instruction.
- Memories have no ports; benches load them by hierarchical writes to byte arrays while the core is held in reset.
- Top-level compute block; no external bus.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/mips_regfile.sv | 32 +++
 rtl/mips_core.sv | 158 +++++++++++++++
 tb/tb_mips_core.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: word width, opcode/funct
// encodings, the ALU operation set and the decoded control bundle.
package mips_pkg;

    localparam int WORD = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst_rd;
        logic    alu_src_imm;
        logic    imm_zero_ext;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch_eq;
        logic    branch_ne;
        logic    jump;
        alu_op_t alu_op;
    } ctrl_t;

    function automatic logic [WORD-1:0] alu_eval(input alu_op_t op,
                                                 input logic [WORD-1:0] a,
                                                 input logic [WORD-1:0] b,
                                                 input logic [4:0] shamt);
        logic [WORD-1:0] y;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = ($signed(a) < $signed(b)) ? {{(WORD-1){1'b0}}, 1'b1} : '0;
            ALU_SLL: y = b << shamt;
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port; register 0 is hardwired to zero on both read and write.
module mips_regfile
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [4:0]      wa,
    input  logic [WORD-1:0] wd,
    output logic [WORD-1:0] rd1,
    output logic [WORD-1:0] rd2
);

    logic [WORD-1:0] inReg [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                inReg[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            inReg[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : inReg[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : inReg[ra2];

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS core: one instruction per rising edge; PC, memories,
// decoder and ALU inline, register file in mips_regfile.
module mips_core
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input logic clk,
    input logic rst
);

    localparam int IAW = $clog2(IMEM_BYTES);
    localparam int DAW = $clog2(DMEM_BYTES);

    logic [WORD-1:0] pc_next;
    logic [WORD-1:0] instr;
    logic [WORD-1:0] rs_val;
    logic [WORD-1:0] rt_val;
    logic [WORD-1:0] alu_b;
    logic [WORD-1:0] alu_y;
    logic [WORD-1:0] load_word;
    logic [WORD-1:0] wd;
    logic [WORD-1:0] imm_ext;
    logic [WORD-1:0] pc_plus4;
    logic [WORD-1:0] branch_target;
    logic [4:0]      wa;
    logic            take_branch;
    ctrl_t           ctrl;

    // Named blocks give the fixed hierarchical paths pc.out, im.mem and dm.mem.
    if (1) begin : pc
        logic [WORD-1:0] out;
        always_ff @(posedge clk) begin
            if (rst) out <= '0;
            else     out <= pc_next;
        end
    end

    if (1) begin : im
        logic [7:0] mem [IMEM_BYTES];
    end

    logic [IAW-1:2] iword;
    assign iword = pc.out[IAW-1:2];
    assign instr = {im.mem[{iword, 2'b11}], im.mem[{iword, 2'b10}],
                    im.mem[{iword, 2'b01}], im.mem[{iword, 2'b00}]};

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    // Anything not decoded leaves ctrl at its default, which is a plain PC+4.
    always_comb begin
        ctrl = '{default: '0, alu_op: ALU_ADD};
        case (op)
            OP_RTYPE: begin
                ctrl.reg_dst_rd = 1'b1;
                ctrl.reg_write  = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    FN_SLL:  ctrl.alu_op = ALU_SLL;
                    default: ctrl.reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OP_ANDI: begin
                ctrl.reg_write    = 1'b1;
                ctrl.alu_src_imm  = 1'b1;
                ctrl.imm_zero_ext = 1'b1;
                ctrl.alu_op       = ALU_AND;
            end
            OP_ORI: begin
                ctrl.reg_write    = 1'b1;
                ctrl.alu_src_imm  = 1'b1;
                ctrl.imm_zero_ext = 1'b1;
                ctrl.alu_op       = ALU_OR;
            end
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
            end
            OP_BEQ:  ctrl.branch_eq = 1'b1;
            OP_BNE:  ctrl.branch_ne = 1'b1;
            OP_J:    ctrl.jump      = 1'b1;
            default: ;
        endcase
    end

    mips_regfile rg (
        .clk (clk),
        .rst (rst),
        .we  (ctrl.reg_write),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (wa),
        .wd  (wd),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    assign imm_ext = ctrl.imm_zero_ext ? {16'b0, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = ctrl.alu_src_imm ? imm_ext : rt_val;
    assign alu_y   = alu_eval(ctrl.alu_op, rs_val, alu_b, shamt);

    logic [DAW-1:2] dword;
    assign dword = alu_y[DAW-1:2];

    if (1) begin : dm
        logic [7:0] mem [DMEM_BYTES];
        // Reset wins over a store issued in the same cycle.
        always_ff @(posedge clk) begin
            if (!rst && ctrl.mem_write) begin
                mem[{dword, 2'b00}] <= rt_val[7:0];
                mem[{dword, 2'b01}] <= rt_val[15:8];
                mem[{dword, 2'b10}] <= rt_val[23:16];
                mem[{dword, 2'b11}] <= rt_val[31:24];
            end
        end
    end

    assign load_word = {dm.mem[{dword, 2'b11}], dm.mem[{dword, 2'b10}],
                        dm.mem[{dword, 2'b01}], dm.mem[{dword, 2'b00}]};
    assign wd = ctrl.mem_to_reg ? load_word : alu_y;
    assign wa = ctrl.reg_dst_rd ? rd : rt;

    assign pc_plus4      = pc.out + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign take_branch   = (ctrl.branch_eq && (rs_val == rt_val)) ||
                           (ctrl.branch_ne && (rs_val != rt_val));

    always_comb begin
        pc_next = pc_plus4;
        if (ctrl.jump)       pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (take_branch) pc_next = branch_target;
    end

endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: programs are loaded under reset, run for a
// fixed number of edges, and architectural state is checked by a monitor.
module tb_mips_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_core #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    localparam int K_PC = 0, K_REG = 1, K_DM = 2, K_IM = 3;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   applied     = 0;
    int   miscompares = 0;
    // Stimulus raises check_req after queueing expectations; the monitor
    // drains the queue against DUT state and drops check_req when done.
    logic check_req   = 1'b0;

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_PC:    return dut.pc.out;
            K_REG:   return dut.rg.inReg[idx];
            K_DM:    return {24'b0, dut.dm.mem[idx]};
            default: return {24'b0, dut.im.mem[idx]};
        endcase
    endfunction

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge check_req);
            #1;
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = actual(e.kind, e.idx);
                applied++;
                if (act !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
                end
            end
            check_req = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction encoders
    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs,
                                          input int rt, input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic expect_val(input int kind, input int idx, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic exp_pc(input logic [31:0] v, input string tag);
        expect_val(K_PC, 0, v, {tag, " pc"});
    endtask

    task automatic exp_reg(input int i, input logic [31:0] v, input string tag);
        expect_val(K_REG, i, v, $sformatf("%s reg[%0d]", tag, i));
    endtask

    task automatic exp_dm(input int i, input logic [7:0] v, input string tag);
        expect_val(K_DM, i, {24'b0, v}, $sformatf("%s dm[%0d]", tag, i));
    endtask

    task automatic checkpoint();
        check_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!check_req) break;
            #1;
        end
        if (check_req) begin
            miscompares++;
            $display("FAIL checkpoint: monitor did not respond, got busy, expected idle");
            exp_q.delete();
            check_req = 1'b0;
        end
    endtask

    task automatic load_prog(input logic [31:0] p[$]);
        rst = 1'b1;
        for (int a = 0; a < 1024; a++) dut.im.mem[a] = 8'h00;
        foreach (p[w]) begin
            dut.im.mem[4*w]     = p[w][7:0];
            dut.im.mem[4*w + 1] = p[w][15:8];
            dut.im.mem[4*w + 2] = p[w][23:16];
            dut.im.mem[4*w + 3] = p[w][31:24];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] prog[$];

        // Reset: preloaded memory survives, registers and PC clear.
        dut.im.mem[0] = 8'hAA; dut.im.mem[1] = 8'hBB;
        dut.dm.mem[100] = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        dut.rg.inReg[5] = 32'd7;
        @(posedge clk);
        @(negedge clk);
        exp_pc(32'd0, "reset");
        for (int i = 0; i < 32; i++) exp_reg(i, 32'd0, "reset");
        expect_val(K_IM, 0, 32'hAA, "reset im[0]");
        expect_val(K_IM, 1, 32'hBB, "reset im[1]");
        exp_dm(100, 8'h5A, "reset");
        checkpoint();

        // Arithmetic
        prog = {i_ins(6'h08, 0, 1, 16'd5), i_ins(6'h08, 0, 2, 16'hFFFD),
                r_ins(1, 2, 3, 0, 6'h20), r_ins(2, 1, 4, 0, 6'h22),
                r_ins(2, 1, 5, 0, 6'h2A)};
        load_prog(prog);
        run(5);
        exp_reg(1, 32'd5, "arith");
        exp_reg(2, 32'hFFFFFFFD, "arith");
        exp_reg(3, 32'd2, "arith");
        exp_reg(4, 32'hFFFFFFF8, "arith");
        exp_reg(5, 32'd1, "arith");
        exp_pc(32'd20, "arith");
        checkpoint();

        // Memory: lw then sw of the loaded word
        prog = {i_ins(6'h23, 0, 6, 16'd0), i_ins(6'h2B, 0, 6, 16'd8)};
        load_prog(prog);
        dut.dm.mem[0] = 8'h78; dut.dm.mem[1] = 8'h56;
        dut.dm.mem[2] = 8'h34; dut.dm.mem[3] = 8'h12;
        for (int a = 8; a < 12; a++) dut.dm.mem[a] = 8'h00;
        run(2);
        exp_reg(6, 32'h12345678, "mem");
        exp_dm(8, 8'h78, "mem");
        exp_dm(9, 8'h56, "mem");
        exp_dm(10, 8'h34, "mem");
        exp_dm(11, 8'h12, "mem");
        exp_pc(32'd8, "mem");
        checkpoint();

        // Branches at PC 8 with $1 == $2 == 4
        prog = {i_ins(6'h08, 0, 1, 16'd4), i_ins(6'h08, 0, 2, 16'd4), i_ins(6'h04, 1, 2, 16'd2)};
        load_prog(prog);
        run(3);
        exp_pc(32'd20, "beq taken");
        checkpoint();

        prog = {i_ins(6'h08, 0, 1, 16'd4), i_ins(6'h08, 0, 2, 16'd4), i_ins(6'h05, 1, 2, 16'd2)};
        load_prog(prog);
        run(3);
        exp_pc(32'd12, "bne not taken");
        checkpoint();

        prog = {i_ins(6'h08, 0, 1, 16'd4), i_ins(6'h08, 0, 2, 16'd4), i_ins(6'h04, 1, 2, 16'hFFFF)};
        load_prog(prog);
        run(3);
        exp_pc(32'd8, "beq -1");
        checkpoint();
        run(1);
        exp_pc(32'd8, "beq -1 again");
        checkpoint();

        // Jump, including a jump past the end of IMEM that wraps the fetch
        prog = {j_ins(26'h10)};
        while (prog.size() < 16) prog.push_back(32'h0);
        prog.push_back(j_ins(26'h100));
        load_prog(prog);
        run(1);
        exp_pc(32'h40, "j 0x10");
        checkpoint();
        run(1);
        exp_pc(32'h400, "j 0x100");
        checkpoint();
        run(1);
        exp_pc(32'h40, "wrapped fetch");
        checkpoint();

        // Undefined opcode and writes to $0
        prog = {i_ins(6'h08, 0, 3, 16'd7), i_ins(6'h3F, 0, 3, 16'd5), i_ins(6'h08, 0, 0, 16'd9)};
        load_prog(prog);
        run(3);
        exp_reg(3, 32'd7, "nop");
        exp_reg(0, 32'd0, "nop");
        exp_dm(0, 8'h78, "nop");
        exp_dm(8, 8'h78, "nop");
        exp_pc(32'd12, "nop");
        checkpoint();

        // Reset mid-program overrides the pending register write
        prog = {i_ins(6'h08, 0, 1, 16'd5), i_ins(6'h08, 0, 2, 16'd6)};
        load_prog(prog);
        run(1);
        exp_reg(1, 32'd5, "pre-reset");
        exp_pc(32'd4, "pre-reset");
        checkpoint();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_reg(1, 32'd0, "mid-reset");
        exp_reg(2, 32'd0, "mid-reset");
        exp_pc(32'd0, "mid-reset");
        checkpoint();

        // Program run: logic ops, shift, wrapped store address, load, slt, bne skip
        prog = {i_ins(6'h08, 0, 1, 16'h00F0),
                i_ins(6'h0D, 1, 2, 16'h8F0F),
                i_ins(6'h0C, 2, 3, 16'hFF00),
                r_ins(0, 1, 4, 4, 6'h00),
                i_ins(6'h08, 0, 5, 16'hFFFF),
                i_ins(6'h2B, 0, 2, 16'd1028),
                i_ins(6'h23, 0, 6, 16'd4),
                r_ins(5, 1, 7, 0, 6'h2A),
                r_ins(1, 5, 8, 0, 6'h2A),
                i_ins(6'h05, 7, 0, 16'd1),
                i_ins(6'h08, 0, 9, 16'd99),
                i_ins(6'h08, 0, 10, 16'h7FFF)};
        load_prog(prog);
        run(10);
        exp_pc(32'd44, "prog");
        exp_reg(1, 32'h000000F0, "prog");
        exp_reg(2, 32'h00008FFF, "prog");
        exp_reg(3, 32'h00008F00, "prog");
        exp_reg(4, 32'h00000F00, "prog");
        exp_reg(5, 32'hFFFFFFFF, "prog");
        exp_reg(6, 32'h00008FFF, "prog");
        exp_reg(7, 32'd1, "prog");
        exp_reg(8, 32'd0, "prog");
        exp_reg(9, 32'd0, "prog");
        exp_dm(4, 8'hFF, "prog");
        exp_dm(5, 8'h8F, "prog");
        exp_dm(6, 8'h00, "prog");
        exp_dm(7, 8'h00, "prog");
        checkpoint();
        run(1);
        exp_reg(10, 32'h00007FFF, "prog");
        exp_pc(32'd48, "prog end");
        checkpoint();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
